// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control: Moore FSM driving the shared memory port, ALU, regfile and PC.
// Define CTRL_BNE_EN to decode opcode 000101 (bne) as a branch; otherwise it is illegal.
//
// state  | meaning
// RESET  | held in reset, all outputs low
// FETCH  | read instruction at PC, PC += 4 when memory completes
// DECODE | register read, branch target into ALUOut
// MEMADR | effective address for lw/sw
// MEMRD  | data read at ALUOut
// MEMWB  | MDR written to rt
// MEMWR  | data write at ALUOut
// EXEC   | R-type ALU operation
// ALUWB  | ALUOut written to rd
// BRANCH | compare A/B, conditional PC update
// ADDIEX | A + immediate
// ADDIWB | ALUOut written to rt
// JUMP   | PC <= jump target
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       reg_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic [1:0] pc_src,
   output logic       branch_ne,
   output logic       illegal,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_RESET  = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   state_t state_q, state_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_RESET;
      else      state_q <= state_d;
   end

   assign state = state_q;

   always_comb begin
      state_d       = state_q;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_ctrl      = ALU_ADD;
      pc_src        = 2'b00;
      branch_ne     = 1'b0;
      illegal       = 1'b0;

      unique case (state_q)
         S_RESET: begin
            alu_ctrl = 3'b000;
            state_d  = S_FETCH;
         end
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // IR and PC latch only on the cycle the read completes
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            unique case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
`ifdef CTRL_BNE_EN
               OP_BNE:       state_d = S_BRANCH;
`endif
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            state_d   = S_ALUWB;
            unique case (funct)
               6'b100000: alu_ctrl = ALU_ADD;
               6'b100010: alu_ctrl = ALU_SUB;
               6'b100100: alu_ctrl = ALU_AND;
               6'b100101: alu_ctrl = ALU_OR;
               6'b101010: alu_ctrl = ALU_SLT;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_ctrl      = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_src        = 2'b01;
`ifdef CTRL_BNE_EN
            branch_ne     = (opcode == OP_BNE);
`endif
            state_d       = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = S_FETCH;
         end
         default: begin
            alu_ctrl = 3'b000;
            state_d  = S_RESET;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class cycle by cycle
// against hand-built control words, including wait states and reset mid-instruction.
module tb_mips_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, ir_write, reg_write, iord;
   logic       mem_read, mem_write, mem_to_reg, reg_dst, alu_src_a;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_ctrl;
   logic       branch_ne, illegal;
   logic [3:0] state;

   int n_checks = 0;
   int n_errors = 0;

   mips_multicycle_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .opcode        (opcode),
      .funct         (funct),
      .mem_ready     (mem_ready),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .ir_write      (ir_write),
      .reg_write     (reg_write),
      .iord          (iord),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_to_reg    (mem_to_reg),
      .reg_dst       (reg_dst),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_ctrl      (alu_ctrl),
      .pc_src        (pc_src),
      .branch_ne     (branch_ne),
      .illegal       (illegal),
      .state         (state)
   );

   always #5 clk = ~clk;

   logic [19:0] ctrl_w;
   assign ctrl_w = {pc_write, pc_write_cond, ir_write, reg_write, iord, mem_read, mem_write,
                    mem_to_reg, reg_dst, alu_src_a, alu_src_b, alu_ctrl, pc_src, branch_ne, illegal};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [19:0] mk(input logic pcw, pcc, irw, rw, io, mr, mw, m2r, rd, asa,
                                      input logic [1:0] asb, input logic [2:0] alc,
                                      input logic [1:0] pcs, input logic bne, ill);
      return {pcw, pcc, irw, rw, io, mr, mw, m2r, rd, asa, asb, alc, pcs, bne, ill};
   endfunction

   // check current state/outputs, then advance one clock
   task automatic cyc(input string tag, input logic [3:0] st, input logic [19:0] cw);
      #1;
      check($sformatf("%s_state", tag), {28'd0, state}, {28'd0, st});
      check($sformatf("%s_ctrl", tag), {12'd0, ctrl_w}, {12'd0, cw});
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         check("rd_wr_excl", {31'd0, mem_read & mem_write}, 32'd0);
         check("rw_wr_excl", {31'd0, reg_write & mem_write}, 32'd0);
      end
   end

   logic [19:0] C_ZERO, C_FETCH, C_FWAIT, C_DEC, C_DECILL, C_MEMADR, C_MEMRD, C_MEMWB, C_MEMWR;
   logic [19:0] C_EXSUB, C_EXOR, C_EXILL, C_ALUWB, C_BREQ, C_BRNE, C_ADDIWB, C_JUMP;

   initial begin
      C_ZERO   = 20'd0;
      C_FETCH  = mk(1,0,1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,0,0);
      C_FWAIT  = mk(0,0,0,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,0,0);
      C_DEC    = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
      C_DECILL = mk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1);
      C_MEMADR = mk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
      C_MEMRD  = mk(0,0,0,0,1,1,0,0,0,0,2'b00,3'b010,2'b00,0,0);
      C_MEMWB  = mk(0,0,0,1,0,0,0,1,0,0,2'b00,3'b010,2'b00,0,0);
      C_MEMWR  = mk(0,0,0,0,1,0,1,0,0,0,2'b00,3'b010,2'b00,0,0);
      C_EXSUB  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0);
      C_EXOR   = mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b001,2'b00,0,0);
      C_EXILL  = mk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,1);
      C_ALUWB  = mk(0,0,0,1,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0);
      C_BREQ   = mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,0);
      C_BRNE   = mk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0);
      C_ADDIWB = mk(0,0,0,1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
      C_JUMP   = mk(1,0,0,0,0,0,0,0,0,0,2'b00,3'b010,2'b10,0,0);

      rst = 1'b0; opcode = 6'b0; funct = 6'b0; mem_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_state", {28'd0, state}, 32'd15);
      check("rst_ctrl", {12'd0, ctrl_w}, 32'd0);
      rst = 1'b1;
      cyc("rel", 4'd15, C_ZERO);

      // FETCH wait then lw with mem_ready tied high
      opcode = 6'b100011;
      cyc("f_wait", 4'd0, C_FWAIT);
      mem_ready = 1'b1;
      cyc("lw_f",   4'd0, C_FETCH);
      cyc("lw_d",   4'd1, C_DEC);
      cyc("lw_ma",  4'd2, C_MEMADR);
      cyc("lw_rd",  4'd3, C_MEMRD);
      cyc("lw_wb",  4'd4, C_MEMWB);

      // sw with three wait cycles in MEMWR
      opcode = 6'b101011;
      cyc("sw_f",   4'd0, C_FETCH);
      cyc("sw_d",   4'd1, C_DEC);
      mem_ready = 1'b0;
      cyc("sw_ma",  4'd2, C_MEMADR);
      for (int i = 0; i < 3; i++) cyc($sformatf("sw_wait%0d", i), 4'd5, C_MEMWR);
      mem_ready = 1'b1;
      cyc("sw_wr",  4'd5, C_MEMWR);

      // R-type sub, then or
      opcode = 6'b000000; funct = 6'b100010;
      cyc("sub_f",  4'd0, C_FETCH);
      cyc("sub_d",  4'd1, C_DEC);
      cyc("sub_ex", 4'd6, C_EXSUB);
      cyc("sub_wb", 4'd7, C_ALUWB);
      funct = 6'b100101;
      cyc("or_f",   4'd0, C_FETCH);
      cyc("or_d",   4'd1, C_DEC);
      cyc("or_ex",  4'd6, C_EXOR);
      cyc("or_wb",  4'd7, C_ALUWB);

      // unsupported funct: no writeback
      funct = 6'b111111;
      cyc("badf_f",  4'd0, C_FETCH);
      cyc("badf_d",  4'd1, C_DEC);
      cyc("badf_ex", 4'd6, C_EXILL);

      // beq
      opcode = 6'b000100; funct = 6'b000000;
      cyc("beq_f",  4'd0, C_FETCH);
      cyc("beq_d",  4'd1, C_DEC);
      cyc("beq_br", 4'd8, C_BREQ);

      // bne: branch or illegal depending on build
      opcode = 6'b000101;
      cyc("bne_f",  4'd0, C_FETCH);
`ifdef CTRL_BNE_EN
      cyc("bne_d",  4'd1, C_DEC);
      cyc("bne_br", 4'd8, C_BRNE);
`else
      cyc("bne_d",  4'd1, C_DECILL);
`endif

      // addi
      opcode = 6'b001000;
      cyc("addi_f",  4'd0, C_FETCH);
      cyc("addi_d",  4'd1, C_DEC);
      cyc("addi_ex", 4'd9, C_MEMADR);
      cyc("addi_wb", 4'd10, C_ADDIWB);

      // j
      opcode = 6'b000010;
      cyc("j_f",  4'd0, C_FETCH);
      cyc("j_d",  4'd1, C_DEC);
      cyc("j_j",  4'd11, C_JUMP);

      // unsupported opcode
      opcode = 6'b111111;
      cyc("ill_f", 4'd0, C_FETCH);
      cyc("ill_d", 4'd1, C_DECILL);

      // reset asserted during a MEMRD wait
      opcode = 6'b100011;
      cyc("ar_f",  4'd0, C_FETCH);
      cyc("ar_d",  4'd1, C_DEC);
      mem_ready = 1'b0;
      cyc("ar_ma", 4'd2, C_MEMADR);
      #1;
      check("ar_wait_state", {28'd0, state}, 32'd3);
      #2;
      rst = 1'b0;
      #1;
      check("ar_async_state", {28'd0, state}, 32'd15);
      check("ar_async_ctrl", {12'd0, ctrl_w}, 32'd0);
      @(posedge clk);
      #1;
      check("ar_hold_state", {28'd0, state}, 32'd15);
      rst = 1'b1;
      cyc("ar_rel",   4'd15, C_ZERO);
      cyc("ar_fwait", 4'd0, C_FWAIT);
      mem_ready = 1'b1;
      cyc("ar_f",     4'd0, C_FETCH);
      #1;
      check("ar_dec_state", {28'd0, state}, 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
